// File: rtl/svutest_regress_sched.sv
// Regression scheduler: launches test channels in index order with bounded parallelism and
// per-test timeouts, then reports tallies. Optional macro SVUTEST_SCHED_STOP_ON_FAIL_EN.
module svutest_regress_sched #(
   parameter int unsigned NUM_TESTS    = 11,
   parameter int unsigned MAX_PARALLEL = 1,
   parameter int unsigned TIMEOUT_W    = 20,
   parameter int unsigned CNT_W        = $clog2(NUM_TESTS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   output logic [NUM_TESTS-1:0] test_start,
   input  logic [NUM_TESTS-1:0] test_done,
   input  logic [NUM_TESTS-1:0] test_pass,
   output logic                 busy,
   output logic                 result_valid,
   output logic [NUM_TESTS-1:0] test_failed,
   output logic [CNT_W-1:0]     pass_count,
   output logic [CNT_W-1:0]     fail_count,
   output logic [CNT_W-1:0]     timeout_count,
   output logic [CNT_W-1:0]     skip_count
);

   localparam int unsigned IDX_W  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
   localparam int unsigned SLOT_W = (MAX_PARALLEL > 1) ? $clog2(MAX_PARALLEL) : 1;
   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_TESTS);
   localparam logic [CNT_W-1:0] PAR_C = CNT_W'(MAX_PARALLEL);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StReport} state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        next_idx_q;
   logic [TIMEOUT_W-1:0]    timeout_q;
   logic [MAX_PARALLEL-1:0] slot_busy_q;
   logic [IDX_W-1:0]        slot_idx_q   [MAX_PARALLEL];
   logic [TIMEOUT_W-1:0]    slot_timer_q [MAX_PARALLEL];

   logic [NUM_TESTS-1:0]    expired;
   logic [NUM_TESTS-1:0]    done_act;
   logic [NUM_TESTS-1:0]    pass_vec;
   logic [NUM_TESTS-1:0]    fail_vec;
   logic [NUM_TESTS-1:0]    timeout_vec;
   logic [NUM_TESTS-1:0]    retire;
   logic [NUM_TESTS-1:0]    launch_vec;
   logic [MAX_PARALLEL-1:0] slot_retire;
   logic [SLOT_W-1:0]       free_slot;
   logic [CNT_W-1:0]        active_count;
   logic [CNT_W-1:0]        pass_inc;
   logic [CNT_W-1:0]        fail_inc;
   logic [CNT_W-1:0]        timeout_inc;
   logic                    halt;
   logic                    launch;

`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
   logic [CNT_W-1:0] skip_q;
   assign skip_count = skip_q;
`else
   assign skip_count = '0;
`endif

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_TESTS-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_TESTS; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   always_comb begin
      expired = '0;
      for (int s = 0; s < MAX_PARALLEL; s++) begin
         if (slot_busy_q[s] && (timeout_q != '0) && (slot_timer_q[s] == timeout_q)) begin
            expired[slot_idx_q[s]] = 1'b1;
         end
      end
      done_act    = test_done & test_start;
      pass_vec    = done_act & test_pass;
      // A done strobe on the expiry edge wins over the timeout.
      timeout_vec = expired & test_start & ~test_done;
      fail_vec    = (done_act & ~test_pass) | timeout_vec;
      retire      = done_act | timeout_vec;

      slot_retire = '0;
      for (int s = 0; s < MAX_PARALLEL; s++) begin
         slot_retire[s] = slot_busy_q[s] & retire[slot_idx_q[s]];
      end

      free_slot = '0;
      for (int s = MAX_PARALLEL - 1; s >= 0; s--) begin
         if (!slot_busy_q[s]) begin
            free_slot = SLOT_W'(s);
         end
      end

      active_count = popcount(test_start);
      pass_inc     = popcount(pass_vec);
      fail_inc     = popcount(fail_vec);
      timeout_inc  = popcount(timeout_vec);

`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
      halt = |fail_vec;
`else
      halt = 1'b0;
`endif
      // Slot freed this edge is not reused until the next one: active_count is registered.
      launch = (state_q == StLaunch) && (active_count < PAR_C) && (next_idx_q < NUM_C) && !halt;

      launch_vec = '0;
      if (launch) begin
         launch_vec[next_idx_q[IDX_W-1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         test_start    <= '0;
         busy          <= 1'b0;
         result_valid  <= 1'b0;
         test_failed   <= '0;
         pass_count    <= '0;
         fail_count    <= '0;
         timeout_count <= '0;
         next_idx_q    <= '0;
         timeout_q     <= '0;
         slot_busy_q   <= '0;
         for (int s = 0; s < MAX_PARALLEL; s++) begin
            slot_idx_q[s]   <= '0;
            slot_timer_q[s] <= '0;
         end
`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
         skip_q        <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (run) begin
                  state_q       <= StLaunch;
                  busy          <= 1'b1;
                  test_failed   <= '0;
                  pass_count    <= '0;
                  fail_count    <= '0;
                  timeout_count <= '0;
                  next_idx_q    <= '0;
                  timeout_q     <= timeout_cycles;
`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
                  skip_q        <= '0;
`endif
               end
            end
            StLaunch, StWait: begin
               test_start    <= (test_start & ~retire) | launch_vec;
               test_failed   <= test_failed | fail_vec;
               pass_count    <= pass_count + pass_inc;
               fail_count    <= fail_count + fail_inc;
               timeout_count <= timeout_count + timeout_inc;
               // Timer starts at 1 so expiry lands exactly timeout_cycles edges after launch.
               for (int s = 0; s < MAX_PARALLEL; s++) begin
                  slot_timer_q[s] <= slot_timer_q[s] + TIMEOUT_W'(1);
                  if (slot_retire[s]) begin
                     slot_busy_q[s] <= 1'b0;
                  end
                  if (launch && (free_slot == SLOT_W'(s))) begin
                     slot_busy_q[s]  <= 1'b1;
                     slot_idx_q[s]   <= next_idx_q[IDX_W-1:0];
                     slot_timer_q[s] <= TIMEOUT_W'(1);
                  end
               end
               if (state_q == StLaunch) begin
                  if (launch) begin
                     next_idx_q <= next_idx_q + CNT_W'(1);
                     if (next_idx_q + CNT_W'(1) == NUM_C) begin
                        state_q <= StWait;
                     end
                  end
`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
                  else if (halt) begin
                     skip_q  <= NUM_C - next_idx_q;
                     state_q <= StWait;
                  end
`endif
               end else if (active_count == '0) begin
                  state_q      <= StReport;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
               end
            end
            StReport: begin
               result_valid <= 1'b0;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_svutest_regress_sched.sv
// Scoreboard bench for svutest_regress_sched: two 4-channel instances (1 and 2 parallel) plus a
// 6-channel stop-on-fail instance when SVUTEST_SCHED_STOP_ON_FAIL_EN is defined.
module tb_svutest_regress_sched;

   localparam int unsigned CW = 3;
   localparam int unsigned TW = 20;

   typedef struct packed {
      logic [7:0] id;
      logic [5:0] failed;
      logic [7:0] p;
      logic [7:0] f;
      logic [7:0] t;
      logic [7:0] s;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run [3];
   logic [TW-1:0] tmo [3];
   logic [5:0]    done_v [3];
   logic [5:0]    pass_v [3];
   logic [5:0]    start_v [3];
   logic [5:0]    failed_v [3];
   logic          busy_v [3];
   logic          rv_v [3];
   logic [CW-1:0] pc [3];
   logic [CW-1:0] fc [3];
   logic [CW-1:0] tc [3];
   logic [CW-1:0] sc [3];
   logic [3:0]    start_a, start_b, failed_a, failed_b;

   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   done_cnt [3];

   int         dly [3][6];
   logic       pv [3][6];
   int         age [3][6];
   logic [5:0] spur [3];

   int         cyc = 0;
   int         viol_onehot = 0;
   int         viol_order = 0;
   int         seq_next = 0;
   int         maxpar_b = 0;
   int         rise2 = 0;
   int         dur2 = 0;
   logic [5:0] prev [3];
   logic [5:0] ever_c = '0;

   always #5 clk = ~clk;

   svutest_regress_sched #(.NUM_TESTS(4), .MAX_PARALLEL(1), .TIMEOUT_W(TW)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .run(run[0]), .timeout_cycles(tmo[0]),
      .test_start(start_a), .test_done(done_v[0][3:0]), .test_pass(pass_v[0][3:0]),
      .busy(busy_v[0]), .result_valid(rv_v[0]), .test_failed(failed_a),
      .pass_count(pc[0]), .fail_count(fc[0]), .timeout_count(tc[0]), .skip_count(sc[0])
   );
   assign start_v[0]  = {2'b00, start_a};
   assign failed_v[0] = {2'b00, failed_a};

   svutest_regress_sched #(.NUM_TESTS(4), .MAX_PARALLEL(2), .TIMEOUT_W(TW)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .run(run[1]), .timeout_cycles(tmo[1]),
      .test_start(start_b), .test_done(done_v[1][3:0]), .test_pass(pass_v[1][3:0]),
      .busy(busy_v[1]), .result_valid(rv_v[1]), .test_failed(failed_b),
      .pass_count(pc[1]), .fail_count(fc[1]), .timeout_count(tc[1]), .skip_count(sc[1])
   );
   assign start_v[1]  = {2'b00, start_b};
   assign failed_v[1] = {2'b00, failed_b};

`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
   svutest_regress_sched #(.NUM_TESTS(6), .MAX_PARALLEL(1), .TIMEOUT_W(TW)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .run(run[2]), .timeout_cycles(tmo[2]),
      .test_start(start_v[2]), .test_done(done_v[2]), .test_pass(pass_v[2]),
      .busy(busy_v[2]), .result_valid(rv_v[2]), .test_failed(failed_v[2]),
      .pass_count(pc[2]), .fail_count(fc[2]), .timeout_count(tc[2]), .skip_count(sc[2])
   );
`else
   assign start_v[2]  = '0;
   assign failed_v[2] = '0;
   assign busy_v[2]   = 1'b0;
   assign rv_v[2]     = 1'b0;
   assign pc[2]       = '0;
   assign fc[2]       = '0;
   assign tc[2]       = '0;
   assign sc[2]       = '0;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   function automatic exp_t mk(input int id, input logic [5:0] fl, input int p, input int f,
                               input int t, input int s);
      exp_t e;
      e.id = 8'(id); e.failed = fl; e.p = 8'(p); e.f = 8'(f); e.t = 8'(t); e.s = 8'(s);
      return e;
   endfunction

   task automatic push_exp(input int d, input exp_t e);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic set_all(input int d, input int dl, input logic p);
      for (int i = 0; i < 6; i++) begin
         dly[d][i] = dl;
         pv[d][i]  = p;
      end
   endtask

   task automatic start_run(input int d, input int t, input exp_t e);
      push_exp(d, e);
      @(negedge clk);
      run[d] = 1'b1;
      tmo[d] = TW'(t);
      @(negedge clk);
      run[d] = 1'b0;
   endtask

   task automatic wait_result(input int d, input int budget, input string name);
      int base;
      int n;
      base = done_cnt[d];
      n = 0;
      while (done_cnt[d] == base && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_cnt[d] == base) check({name, "_completed"}, 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero(input int d, input string tag);
      check({tag, "_test_start"}, 64'(start_v[d]), 0);
      check({tag, "_busy"}, 64'(busy_v[d]), 0);
      check({tag, "_result_valid"}, 64'(rv_v[d]), 0);
      check({tag, "_test_failed"}, 64'(failed_v[d]), 0);
      check({tag, "_pass_count"}, 64'(pc[d]), 0);
      check({tag, "_fail_count"}, 64'(fc[d]), 0);
      check({tag, "_timeout_count"}, 64'(tc[d]), 0);
      check({tag, "_skip_count"}, 64'(sc[d]), 0);
   endtask

   // Channel responder: done pulse dly cycles after start rises, plus forced spurious strobes.
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) begin
               if (start_v[d][i] === 1'b1) age[d][i]++;
               else age[d][i] = 0;
               done_v[d][i] = spur[d][i] |
                              ((start_v[d][i] === 1'b1) && dly[d][i] != 0 && age[d][i] == dly[d][i]);
               pass_v[d][i] = spur[d][i] ? 1'b0 : pv[d][i];
            end
         end
      end
   end

   initial forever @(posedge clk) cyc++;

   // Launch-pattern observer.
   initial begin
      logic [5:0] rising;
      logic [5:0] falling;
      for (int d = 0; d < 3; d++) prev[d] = '0;
      forever begin
         @(negedge clk);
         rising  = start_v[0] & ~prev[0];
         falling = prev[0] & ~start_v[0];
         if ($countones(start_v[0]) > 1) viol_onehot++;
         for (int i = 0; i < 6; i++) begin
            if (rising[i]) begin
               if (i != seq_next) viol_order++;
               seq_next++;
            end
         end
         if (rising[2]) rise2 = cyc;
         if (falling[2]) dur2 = cyc - rise2;
         if ($countones(start_v[1]) > maxpar_b) maxpar_b = $countones(start_v[1]);
         ever_c = ever_c | start_v[2];
         for (int d = 0; d < 3; d++) prev[d] = start_v[d];
      end
   end

   // Result monitor: pops the scoreboard whenever a result_valid pulse appears.
   initial begin
      exp_t e;
      logic have;
      for (int d = 0; d < 3; d++) done_cnt[d] = 0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (rv_v[d] === 1'b1) begin
               have = 1'b0;
               if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               if (d == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
               if (!have) begin
                  check($sformatf("dut%0d_unexpected_result_valid", d), 1, 0);
               end else begin
                  check($sformatf("s%0d_pass_count", e.id), 64'(pc[d]), 64'(e.p));
                  check($sformatf("s%0d_fail_count", e.id), 64'(fc[d]), 64'(e.f));
                  check($sformatf("s%0d_timeout_count", e.id), 64'(tc[d]), 64'(e.t));
                  check($sformatf("s%0d_skip_count", e.id), 64'(sc[d]), 64'(e.s));
                  check($sformatf("s%0d_test_failed", e.id), 64'(failed_v[d]), 64'(e.failed));
                  check($sformatf("s%0d_busy_low", e.id), 64'(busy_v[d]), 0);
               end
               done_cnt[d]++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         run[d] = 1'b0;
         tmo[d] = '0;
         spur[d] = '0;
         set_all(d, 3, 1'b1);
         for (int i = 0; i < 6; i++) age[d][i] = 0;
      end

      #12;
      check_zero(0, "rst_a");
      check_zero(1, "rst_b");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_zero(0, "idle_a");

      // S1: one at a time, all pass after 3 cycles
      seq_next = 0;
      set_all(0, 3, 1'b1);
      start_run(0, 0, mk(1, 6'b000000, 4, 0, 0, 0));
      check("s1_busy_at_accept", 64'(busy_v[0]), 1);
      check("s1_start_not_yet", 64'(start_v[0]), 0);
      @(negedge clk);
      check("s1_start0_next_cycle", 64'(start_v[0]), 1);
      wait_result(0, 100, "s1");

      // S2: two in parallel, test 1 fails
      maxpar_b = 0;
      set_all(1, 3, 1'b1);
      pv[1][1] = 1'b0;
`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
      start_run(1, 0, mk(2, 6'b000010, 1, 1, 0, 2));
`else
      start_run(1, 0, mk(2, 6'b000010, 3, 1, 0, 0));
`endif
      wait_result(1, 100, "s2");
      check("s2_max_parallel", 64'(maxpar_b), 2);

      // S3: test 2 never finishes, timeout 5
      seq_next = 0;
      dur2 = 0;
      set_all(0, 3, 1'b1);
      dly[0][2] = 0;
`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
      start_run(0, 5, mk(3, 6'b000100, 2, 1, 1, 1));
`else
      start_run(0, 5, mk(3, 6'b000100, 3, 1, 1, 0));
`endif
      wait_result(0, 100, "s3");
      check("s3_timeout_duration", 64'(dur2), 5);

      // S4: done coincides with expiry, done wins
      seq_next = 0;
      dur2 = 0;
      set_all(0, 3, 1'b1);
      dly[0][2] = 5;
      start_run(0, 5, mk(4, 6'b000000, 4, 0, 0, 0));
      wait_result(0, 100, "s4");
      check("s4_done_duration", 64'(dur2), 5);

      // S5: spurious fail strobe on inactive test 3 and a run pulse while busy
      seq_next = 0;
      set_all(0, 3, 1'b1);
      start_run(0, 0, mk(5, 6'b000000, 4, 0, 0, 0));
      @(posedge clk);
      #2;
      spur[0][3] = 1'b1;
      run[0] = 1'b1;
      @(posedge clk);
      #2;
      spur[0][3] = 1'b0;
      run[0] = 1'b0;
      wait_result(0, 100, "s5");
      repeat (20) @(negedge clk);
      check("s5_result_once", 64'(done_cnt[0]), 4);
      check("a_onehot_violations", 64'(viol_onehot), 0);
      check("a_order_violations", 64'(viol_order), 0);

      // S6: reset with two tests active, then a clean run
      set_all(1, 20, 1'b1);
      start_run(1, 0, mk(6, 6'b000000, 4, 0, 0, 0));
      repeat (3) @(negedge clk);
      check("s6_two_active", 64'($countones(start_v[1])), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero(1, "s6_in_reset");
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("s6_no_result_after_reset", 64'(done_cnt[1]), 1);
      set_all(1, 3, 1'b1);
      start_run(1, 0, mk(7, 6'b000000, 4, 0, 0, 0));
      wait_result(1, 100, "s7");

`ifdef SVUTEST_SCHED_STOP_ON_FAIL_EN
      // S8: stop on first failure, remaining tests skipped
      set_all(2, 3, 1'b1);
      pv[2][1] = 1'b0;
      start_run(2, 0, mk(8, 6'b000010, 1, 1, 0, 4));
      wait_result(2, 100, "s8");
      repeat (10) @(negedge clk);
      check("s8_unlaunched_never_started", 64'(ever_c & 6'b111100), 0);
      check("s8_launched", 64'(ever_c & 6'b000011), 3);
`endif

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
